vga_mem_arbiter: RTL and testbench

VGA_MEM_ARBITER -- requirements
Module: vga_mem_arbiter

---
 rtl/vga_pkg.sv | 15 +
 rtl/vga_wr_fifo.sv | 52 +++++
 rtl/vga_mem_arbiter.sv | 136 +++++++++++++
 tb/tb_vga_mem_arbiter.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/vga_pkg.sv
// rtl/vga_pkg.sv - shared state encoding and width constants for the VGA memory arbiter
package vga_pkg;

  typedef enum logic {
    WAIT_FRAME = 1'b0,
    RUN        = 1'b1
  } vga_state_t;

  localparam int ADDR_W       = 16;
  localparam int DATA_W       = 8;
  localparam int COORD_W      = 11;
  localparam int PIX_PER_WORD = 8;
  localparam int WR_ENTRY_W   = ADDR_W + DATA_W;

endpackage

// File: rtl/vga_wr_fifo.sv
// rtl/vga_wr_fifo.sv - write queue between the writer channel and the shared memory port
module vga_wr_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 24
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output logic             empty,
  output logic             full
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [WIDTH-1:0] store [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W:0]   count;
  logic             do_push;
  logic             do_pop;

  assign empty   = (count == '0);
  assign full    = (count == (PTR_W+1)'(DEPTH));
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign head    = store[rd_ptr];

  // DEPTH is a power of two, so the pointers wrap by plain overflow
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) store[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/vga_mem_arbiter.sv
// rtl/vga_mem_arbiter.sv - shares one memory port between display fetch and a write queue
// Optional stall statistics output compiled in with VGA_ARB_STATS_EN.
module vga_mem_arbiter
  import vga_pkg::*;
#(
  parameter int H_WORDS    = 80,
  parameter int FIFO_DEPTH = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               en,
  input  logic               ready,
  input  logic [COORD_W-1:0] x_addr,
  input  logic [COORD_W-1:0] y_addr,
  input  logic               wr_valid,
  output logic               wr_ready,
  input  logic [ADDR_W-1:0]  wr_addr,
  input  logic [DATA_W-1:0]  wr_data,
  output logic               mem_en,
  output logic               mem_we,
  output logic [ADDR_W-1:0]  mem_addr,
  output logic [DATA_W-1:0]  mem_wdata,
  input  logic [DATA_W-1:0]  mem_rdata,
`ifdef VGA_ARB_STATS_EN
  output logic [15:0]        stall_cnt,
`endif
  output logic               pix,
  output logic               pix_valid,
  output logic               frame_start
);

  localparam int SEL_W = $clog2(PIX_PER_WORD);

  vga_state_t             state;
  vga_state_t             state_nxt;
  logic                   frame_hit;
  logic                   active;
  logic                   disp_rd;
  logic [ADDR_W-1:0]      rd_addr;
  logic [WR_ENTRY_W-1:0]  fifo_head;
  logic                   fifo_empty;
  logic                   fifo_full;
  logic                   fifo_pop;
  logic                   rd_d1;
  logic                   sched_d1;
  logic [SEL_W-1:0]       bit_sel_d1;
  logic [DATA_W-1:0]      word_q;
  logic [DATA_W-1:0]      word_now;

  assign frame_hit = en && ready && (x_addr == '0) && (y_addr == '0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= WAIT_FRAME;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      WAIT_FRAME: if (frame_hit) state_nxt = RUN;
      RUN:        if (!en)       state_nxt = WAIT_FRAME;
      default:    state_nxt = WAIT_FRAME;
    endcase
  end

  // active covers the entry cycle so the first word of a frame is fetched at once
  always_comb begin
    frame_start = 1'b0;
    active      = 1'b0;
    case (state)
      WAIT_FRAME: begin
        frame_start = frame_hit && !rst;
        active      = frame_hit;
      end
      RUN:     active = en;
      default: active = 1'b0;
    endcase
  end

  assign disp_rd  = active && ready && (x_addr[SEL_W-1:0] == '0) && !rst;
  assign rd_addr  = ADDR_W'(y_addr) * ADDR_W'(H_WORDS) + ADDR_W'(x_addr[COORD_W-1:SEL_W]);
  assign fifo_pop = !disp_rd && !fifo_empty;
  assign wr_ready = !fifo_full;

  vga_wr_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (WR_ENTRY_W)
  ) u_wr_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (wr_valid),
    .push_data ({wr_addr, wr_data}),
    .pop       (fifo_pop),
    .head      (fifo_head),
    .empty     (fifo_empty),
    .full      (fifo_full)
  );

  assign mem_en    = disp_rd || (!fifo_empty && !rst);
  assign mem_we    = fifo_pop && !rst;
  assign mem_addr  = disp_rd ? rd_addr : fifo_head[WR_ENTRY_W-1:DATA_W];
  assign mem_wdata = fifo_head[DATA_W-1:0];

  // Fresh read data bypasses the word register so column x lands exactly two cycles later
  assign word_now = rd_d1 ? mem_rdata : word_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_d1      <= 1'b0;
      sched_d1   <= 1'b0;
      bit_sel_d1 <= '0;
      word_q     <= '0;
      pix        <= 1'b0;
      pix_valid  <= 1'b0;
    end else begin
      rd_d1      <= disp_rd;
      sched_d1   <= active && ready;
      bit_sel_d1 <= SEL_W'(PIX_PER_WORD - 1) - x_addr[SEL_W-1:0];
      word_q     <= word_now;
      pix        <= sched_d1 && word_now[bit_sel_d1];
      pix_valid  <= sched_d1;
    end
  end

`ifdef VGA_ARB_STATS_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      stall_cnt <= '0;
    else if (frame_start)
      stall_cnt <= '0;
    else if (wr_valid && !wr_ready && (stall_cnt != 16'hFFFF))
      stall_cnt <= stall_cnt + 1'b1;
  end
`endif

endmodule

// File: tb/tb_vga_mem_arbiter.sv
// tb/tb_vga_mem_arbiter.sv - randomized raster and writer traffic against a reference model
module tb_vga_mem_arbiter;

  localparam int H_WORDS = 80;
  localparam int DEPTH   = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        en;
  logic        ready;
  logic [10:0] x_addr;
  logic [10:0] y_addr;
  logic        wr_valid;
  logic        wr_ready;
  logic [15:0] wr_addr;
  logic [7:0]  wr_data;
  logic        mem_en;
  logic        mem_we;
  logic [15:0] mem_addr;
  logic [7:0]  mem_wdata;
  logic [7:0]  mem_rdata;
  logic        pix;
  logic        pix_valid;
  logic        frame_start;
`ifdef VGA_ARB_STATS_EN
  logic [15:0] stall_cnt;
`endif

  always #5 clk = ~clk;

  vga_mem_arbiter #(.H_WORDS(H_WORDS), .FIFO_DEPTH(DEPTH)) dut (
    .clk         (clk),
    .rst         (rst),
    .en          (en),
    .ready       (ready),
    .x_addr      (x_addr),
    .y_addr      (y_addr),
    .wr_valid    (wr_valid),
    .wr_ready    (wr_ready),
    .wr_addr     (wr_addr),
    .wr_data     (wr_data),
    .mem_en      (mem_en),
    .mem_we      (mem_we),
    .mem_addr    (mem_addr),
    .mem_wdata   (mem_wdata),
    .mem_rdata   (mem_rdata),
`ifdef VGA_ARB_STATS_EN
    .stall_cnt   (stall_cnt),
`endif
    .pix         (pix),
    .pix_valid   (pix_valid),
    .frame_start (frame_start)
  );

  int          checks   = 0;
  int          failures = 0;
  logic [7:0]  rom [256];
  bit          m_run;
  logic [23:0] m_q [$];
  bit          h_v [2];
  bit          h_b [2];
  int          m_stall;
  bit          en_cur;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] word_at(input logic [15:0] a);
    return rom[a[7:0]];
  endfunction

  task automatic model_reset();
    m_run = 0;
    m_q.delete();
    h_v[0] = 0; h_v[1] = 0;
    h_b[0] = 0; h_b[1] = 0;
    m_stall = 0;
  endtask

  // Entered at posedge+1 with inputs applied; leaves at the next posedge+1.
  task automatic run_cycle();
    bit          start;
    bit          act;
    bit          rd;
    bit          full;
    bit          push;
    bit          pop;
    bit          px_v;
    bit          px_b;
    logic [15:0] ra;
    logic [7:0]  w;
    #3;
    start = !m_run && en && ready && (x_addr == 0) && (y_addr == 0);
    act   = (m_run && en) || start;
    rd    = act && ready && (x_addr % 8 == 0);
    ra    = 16'((int'(y_addr) * H_WORDS + int'(x_addr) / 8) % 65536);
    full  = (m_q.size() == DEPTH);

    check("frame_start", frame_start, start);
    check("wr_ready", wr_ready, !full);
    check("mem_en", mem_en, rd || (m_q.size() > 0));
    check("mem_we", mem_we, !rd && (m_q.size() > 0));
    if (rd) begin
      check("rd_addr", mem_addr, ra);
      if (y_addr == 2 && x_addr == 16) check("addr_162", mem_addr, 16'd162);
    end else if (m_q.size() > 0) begin
      check("wr_addr", mem_addr, m_q[0][23:8]);
      check("wr_data", mem_wdata, m_q[0][7:0]);
    end
    check("pix_valid", pix_valid, h_v[1]);
    check("pix", pix, h_b[1]);
`ifdef VGA_ARB_STATS_EN
    check("stall_cnt", stall_cnt, m_stall);
    if (start) m_stall = 0;
    else if (wr_valid && full && m_stall != 65535) m_stall++;
`endif

    px_v = act && ready;
    w    = word_at(ra);
    px_b = px_v && w[7 - (int'(x_addr) % 8)];
    pop  = !rd && (m_q.size() > 0);
    push = wr_valid && !full;
    if (pop)  void'(m_q.pop_front());
    if (push) m_q.push_back({wr_addr, wr_data});
    if (start) m_run = 1;
    else if (!en) m_run = 0;
    h_v[1] = h_v[0]; h_v[0] = px_v;
    h_b[1] = h_b[0]; h_b[0] = px_b;

    @(posedge clk);
    #1;
    mem_rdata = rd ? word_at(ra) : 8'($urandom);
  endtask

  task automatic drive(input bit e, input bit r, input int x, input int y, input bit wv);
    en       = e;
    ready    = r;
    x_addr   = 11'(x);
    y_addr   = 11'(y);
    wr_valid = wv;
    wr_addr  = 16'($urandom);
    wr_data  = 8'($urandom);
    run_cycle();
  endtask

  task automatic frame(input bit drop);
    en_cur = 1;
    for (int y = 0; y < 4; y++) begin
      for (int x = 0; x < 32; x++) begin
        if ($urandom_range(7) == 0)
          repeat ($urandom_range(1, 3)) drive(en_cur, 0, x, y, 1'($urandom_range(1)));
        if (drop && y == 1 && x == 13) en_cur = 0;
        if (drop && y == 2 && x == 4)  en_cur = 1;
        drive(en_cur, 1, x, y, 1'($urandom_range(1)));
      end
      repeat (4) drive(en_cur, 0, 32, y, 1'($urandom_range(1)));
    end
  endtask

  initial begin
    for (int i = 0; i < 256; i++) rom[i] = 8'($urandom);
    rom[162] = 8'hA5;
    rst = 1; en = 1; ready = 1; x_addr = 0; y_addr = 0;
    wr_valid = 1; wr_addr = 16'h1234; wr_data = 8'h56; mem_rdata = 0;
    model_reset();
    repeat (2) @(posedge clk);
    #3;
    check("rst_frame_start", frame_start, 0);
    check("rst_mem_en", mem_en, 0);
    check("rst_mem_we", mem_we, 0);
    check("rst_wr_ready", wr_ready, 1);
    check("rst_pix_valid", pix_valid, 0);
    check("rst_pix", pix, 0);
    @(posedge clk);
    #1;
    en = 0; wr_valid = 0;
    rst = 0;

    for (int f = 0; f < 5; f++) frame(f == 1 || f == 3);

    repeat (6) drive(0, 0, 0, 0, 0);
    drive(1, 1, 0, 0, 0);
    repeat (14) drive(1, 1, 0, 0, 1);
`ifdef VGA_ARB_STATS_EN
    #1;
    check("stall_cnt_10", stall_cnt, 16'd10);
`endif
    repeat (6) drive(0, 0, 0, 0, 0);
    drive(1, 1, 0, 0, 0);
    repeat (3) drive(1, 1, 0, 0, 1);

    rst = 1;
    #1;
    check("midrst_mem_en", mem_en, 0);
    check("midrst_wr_ready", wr_ready, 1);
    check("midrst_pix_valid", pix_valid, 0);
    check("midrst_frame_start", frame_start, 0);
    @(posedge clk);
    #1;
    rst = 0;
    model_reset();
    mem_rdata = 8'($urandom);
    repeat (6) drive(0, 0, 0, 0, 0);

    frame(0);
    repeat (4) drive(0, 0, 0, 0, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
